// File: rtl/mem_access_unit.sv
// mem_access_unit: bridges byte/half/word core loads and stores onto a
// word-wide memory port. Sub-word stores run as read-modify-write.
// Optional feature macro: MAU_TIMEOUT_EN (ack-wait limit of TIMEOUT_CYCLES).
// Handshake: a request is taken in IDLE when req_valid=1. In RD/WR,
// mem_req stays high with stable mem_addr/mem_we/mem_wdata until a cycle
// in which mem_ack=1 is sampled on the rising clock edge.
module mem_access_unit #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [1:0]  req_op,
   input  logic        req_ext,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] rdata,
   output logic        misalign,
   output logic        timeout,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic [2:0]  o_dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_WR   = 3'd2,
      S_DONE = 3'd3,
      S_ERR  = 3'd4
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic        r_write;
   logic [1:0]  r_op;
   logic        r_ext;
   logic [1:0]  r_lo;
   logic [15:0] r_wdata;
   logic [31:0] r_rdata;
   logic [31:0] r_mem_addr;
   logic [31:0] r_mem_wdata;
   logic        r_to_flag;
   logic        w_to_hit;
   logic        w_req_word;
   logic        w_req_mis;
   logic        w_is_byte;
   logic        w_is_half;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load;
   logic [31:0] w_merge;

   // 2'b11 falls through to word handling
   assign w_req_word = (req_op != 2'b01) && (req_op != 2'b10);
   assign w_req_mis  = ((req_op == 2'b01) && req_addr[0]) ||
                       (w_req_word && (req_addr[1:0] != 2'b00));
   assign w_is_byte  = (r_op == 2'b10);
   assign w_is_half  = (r_op == 2'b01);

   assign busy        = (r_state != S_IDLE);
   assign done        = (r_state == S_DONE);
   assign misalign    = (r_state == S_ERR) && !r_to_flag;
   assign timeout     = (r_state == S_ERR) && r_to_flag;
   assign mem_req     = (r_state == S_RD) || (r_state == S_WR);
   assign mem_we      = (r_state == S_WR);
   assign mem_addr    = r_mem_addr;
   assign mem_wdata   = r_mem_wdata;
   assign rdata       = r_rdata;
   assign o_dbg_state = r_state;

`ifdef MAU_TIMEOUT_EN
   localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CW-1:0] r_wait_cnt;

   // the limit is reached in the cycle that would make the count TIMEOUT_CYCLES
   assign w_to_hit = mem_req && !mem_ack && (r_wait_cnt == CW'(TIMEOUT_CYCLES - 1));

   // wait counter: cleared on any state change, counts unacknowledged request cycles
   always_ff @(posedge clk) begin
      if (rst || !mem_req || (w_next != r_state)) r_wait_cnt <= '0;
      else if (!mem_ack)                         r_wait_cnt <= r_wait_cnt + 1'b1;
   end
`else
   // no ack limit: the parameter is kept only so both builds share one interface
   assign w_to_hit = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

   // state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // next-state decode
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (req_valid) begin
               if (w_req_mis)                    w_next = S_ERR;
               else if (!req_write || !w_req_word) w_next = S_RD;
               else                              w_next = S_WR;
            end
         end
         S_RD: begin
            if (w_to_hit)     w_next = S_ERR;
            else if (mem_ack) w_next = r_write ? S_WR : S_DONE;
         end
         S_WR: begin
            if (w_to_hit)     w_next = S_ERR;
            else if (mem_ack) w_next = S_DONE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // lane extraction with extension for loads, lane merge for sub-word stores
   always_comb begin
      w_byte  = mem_rdata[7:0];
      w_half  = r_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      w_load  = mem_rdata;
      w_merge = mem_rdata;
      case (r_lo)
         2'd1:    w_byte = mem_rdata[15:8];
         2'd2:    w_byte = mem_rdata[23:16];
         2'd3:    w_byte = mem_rdata[31:24];
         default: w_byte = mem_rdata[7:0];
      endcase
      if (w_is_byte) begin
         w_load = r_ext ? {{24{w_byte[7]}}, w_byte} : {24'h0, w_byte};
         case (r_lo)
            2'd1:    w_merge[15:8]  = r_wdata[7:0];
            2'd2:    w_merge[23:16] = r_wdata[7:0];
            2'd3:    w_merge[31:24] = r_wdata[7:0];
            default: w_merge[7:0]   = r_wdata[7:0];
         endcase
      end else if (w_is_half) begin
         w_load = r_ext ? {{16{w_half[15]}}, w_half} : {16'h0, w_half};
         if (r_lo[1]) w_merge[31:16] = r_wdata;
         else         w_merge[15:0]  = r_wdata;
      end
   end

   // request capture, load result and write-word construction
   always_ff @(posedge clk) begin
      if (rst) begin
         r_write     <= 1'b0;
         r_op        <= 2'b00;
         r_ext       <= 1'b0;
         r_lo        <= 2'b00;
         r_wdata     <= 16'h0;
         r_rdata     <= 32'h0;
         r_mem_addr  <= 32'h0;
         r_mem_wdata <= 32'h0;
         r_to_flag   <= 1'b0;
      end else begin
         r_to_flag <= w_to_hit;
         if ((r_state == S_IDLE) && req_valid) begin
            r_write    <= req_write;
            r_op       <= req_op;
            r_ext      <= req_ext;
            r_lo       <= req_addr[1:0];
            r_wdata    <= req_wdata[15:0];
            r_mem_addr <= {req_addr[31:2], 2'b00};
            if (req_write && w_req_word) r_mem_wdata <= req_wdata;
         end else if ((r_state == S_RD) && mem_ack) begin
            if (r_write) r_mem_wdata <= w_merge;
            else         r_rdata     <= w_load;
         end
      end
   end

endmodule
